// File: rtl/io_border_pkg.sv
// io_border_pkg: select codes and config field layout helpers for io_border_tile
package io_border_pkg;
  typedef enum logic [1:0] {SEL_OFF = 2'd0, SEL_A = 2'd1, SEL_B = 2'd2, SEL_PAD = 2'd3} sel_e;
  function automatic int pin_w(input int tracks);
    return 2 + $clog2(tracks);
  endfunction
  function automatic int cfg_bits(input int tracks, input int pins);
    return 6 * tracks + pins * pin_w(tracks);
  endfunction
  function automatic int side_off(input int tracks, input int side);
    return 2 * tracks * side;
  endfunction
  function automatic int pin_off(input int tracks, input int p);
    return 6 * tracks + p * pin_w(tracks);
  endfunction
endpackage

// File: rtl/border_pin_cell.sv
// border_pin_cell: one pad with optional register, direction control and track-side pad value
module border_pin_cell #(
  parameter int TRACKS = 8,
  localparam int SELW = $clog2(TRACKS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dir,
  input  logic            reg_en,
  input  logic [SELW-1:0] src,
  input  logic [TRACKS-1:0] inner_in,
  input  logic            pad_in,
  output logic            pad_out,
  output logic            pad_oe,
  output logic            pad_val
);
  logic pin_q, pin_d, inner_bit;
  always_comb begin
    inner_bit = inner_in[src];
    pin_d = dir ? inner_bit : pad_in;
  end
  always_ff @(posedge clk) begin
    if (rst) pin_q <= 1'b0;
    else pin_q <= pin_d;
  end
  assign pad_oe = dir;
  assign pad_out = dir & (reg_en ? pin_q : inner_bit);
  // an output pin presents 0 to the track switches
  assign pad_val = ~dir & (reg_en ? pin_q : pad_in);
endmodule

// File: rtl/io_border_tile.sv
// io_border_tile: scan-configured edge tile routing prev/next/inner buses and pads; CFG_PARITY_EN adds an even-parity chain bit
module io_border_tile
  import io_border_pkg::*;
#(
  parameter int TRACKS = 8,
  parameter int IO_PINS = 2,
  localparam int SELW = $clog2(TRACKS),
  localparam int CFG_BITS = cfg_bits(TRACKS, IO_PINS)
) (
  input  logic               PCLK,
  input  logic               RST,
  input  logic               SE,
  input  logic               SIN,
  output logic               SOUT,
  output logic               CFG_DONE,
  output logic               CFG_ERR,
  input  logic [TRACKS-1:0]  PREV_IN,
  input  logic [TRACKS-1:0]  NEXT_IN,
  input  logic [TRACKS-1:0]  INNER_IN,
  output logic [TRACKS-1:0]  PREV_OUT,
  output logic [TRACKS-1:0]  NEXT_OUT,
  output logic [TRACKS-1:0]  INNER_OUT,
  input  logic [IO_PINS-1:0] PAD_IN,
  output logic [IO_PINS-1:0] PAD_OUT,
  output logic [IO_PINS-1:0] PAD_OE
);
`ifdef CFG_PARITY_EN
  localparam int CHAIN = CFG_BITS + 1;
`else
  localparam int CHAIN = CFG_BITS;
`endif
  localparam int CW = $clog2(CHAIN + 2);
  logic [CHAIN-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic se_q, done_q, done_d, err_q, err_d, se_rise, commit, good, par_ok;
  logic [IO_PINS-1:0] pad_val;
  logic [TRACKS-1:0] src_a [3];
  logic [TRACKS-1:0] src_b [3];
  logic [TRACKS-1:0] bus_out [3];
  sel_e sel;
`ifdef CFG_PARITY_EN
  assign par_ok = ~^shadow_q;
`else
  assign par_ok = 1'b1;
`endif
  always_comb begin
    se_rise = SE & ~se_q;
    commit = ~SE & se_q;
    good = commit && cnt_q == CW'(CHAIN) && par_ok;
    shadow_d = SE ? {SIN, shadow_q[CHAIN-1:1]} : shadow_q;
    cnt_d = se_rise ? CW'(1) : (SE && cnt_q != CW'(CHAIN + 1)) ? cnt_q + CW'(1) : cnt_q;
    active_d = good ? shadow_q[CFG_BITS-1:0] : active_q;
    done_d = good;
    err_d = ~se_rise & (err_q | (commit & ~good));
  end
  always_ff @(posedge PCLK) begin
    if (RST) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q <= '0;
      se_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q <= cnt_d;
      se_q <= SE;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign SOUT = shadow_q[0];
  assign CFG_DONE = done_q;
  assign CFG_ERR = err_q;
  // sides: 0 = prev, 1 = next, 2 = inner; a/b are the two other sources in order
  assign src_a[0] = NEXT_IN;
  assign src_b[0] = INNER_IN;
  assign src_a[1] = PREV_IN;
  assign src_b[1] = INNER_IN;
  assign src_a[2] = PREV_IN;
  assign src_b[2] = NEXT_IN;
  always_comb begin
    sel = SEL_OFF;
    bus_out = '{default: '0};
    for (int s = 0; s < 3; s++)
      for (int t = 0; t < TRACKS; t++) begin
        sel = sel_e'(active_q[side_off(TRACKS, s) + 2 * t +: 2]);
        bus_out[s][t] = sel == SEL_A ? src_a[s][t] : sel == SEL_B ? src_b[s][t] :
                        sel == SEL_PAD ? pad_val[t % IO_PINS] : 1'b0;
      end
  end
  assign PREV_OUT = bus_out[0];
  assign NEXT_OUT = bus_out[1];
  assign INNER_OUT = bus_out[2];
  for (genvar p = 0; p < IO_PINS; p++) begin : g_pin
    localparam int off = pin_off(TRACKS, p);
    border_pin_cell #(.TRACKS(TRACKS)) u_cell (
      .clk(PCLK),
      .rst(RST),
      .dir(active_q[off]),
      .reg_en(active_q[off + 1]),
      .src(active_q[off + 2 +: SELW]),
      .inner_in(INNER_IN),
      .pad_in(PAD_IN[p]),
      .pad_out(PAD_OUT[p]),
      .pad_oe(PAD_OE[p]),
      .pad_val(pad_val[p])
    );
  end
endmodule

// File: doc/io_border_tile.md
Name: io_border_tile

Overview:
Parametrised overlay border tile: routes the edge-running track bus and the inner bus between three sides, and connects IO_PINS pads to tracks. It replaces the fixed-width east/west border tiles with a single generic tile placed on any edge. Configuration is loaded through the existing serial scan chain into a shadow register. The shadow is committed to the active configuration only after a complete, correctly counted load. Each pin can be registered or combinational and set to input or output.

Parameters:
TRACKS, 8, tracks per bus; power of 2, ≥2.
IO_PINS, 2, pads served by this tile; 1..TRACKS.
SELW, $clog2(TRACKS), derived; track-select width.
CFG_BITS, 6*TRACKS + IO_PINS*(2+SELW), derived; scan chain length (58 at defaults).

Ports:
PCLK  in  1  clock; all state on rising edge.
RST  in  1  synchronous, active-high reset.
SE  in  1  scan enable; shift when high.
SIN  in  1  scan data in.
SOUT  out  1  scan data out = shadow bit 0.
CFG_DONE  out  1  one-cycle pulse on successful commit.
CFG_ERR  out  1  sticky: last load had a wrong bit count.
PREV_IN / NEXT_IN / INNER_IN  in  TRACKS  bus inputs from the previous edge tile, the next edge tile and the interior.
PREV_OUT / NEXT_OUT / INNER_OUT  out  TRACKS  bus outputs to the same three neighbours.
PAD_IN  in  IO_PINS  pad receive data.
PAD_OUT  out  IO_PINS  pad drive data.
PAD_OE  out  IO_PINS  pad output enable.

Behaviour:
- Reset values. Shadow register, active config, bit counter, se_q, pin registers, CFG_DONE and CFG_ERR are all 0. With an all-zero active config, every output is 0 and SOUT is 0.
- Shift. On each cycle with SE=1: shadow <= {SIN, shadow[CFG_BITS-1:1]}. The counter increments and saturates at CFG_BITS+1. On an SE rising edge (SE=1, se_q=0), the counter loads 1 and CFG_ERR clears.
- Commit. Triggered by the cycle with SE=0 and se_q=1.
  - If count==CFG_BITS: active <= shadow and CFG_DONE=1 for exactly one cycle.
  - Otherwise: active is unchanged and CFG_ERR <= 1.
- SE low with no prior shift does not commit.
- RST during a shift aborts it. se_q resets to 0, so no spurious commit follows.
- Field layout (active config):
  - [2t+1:2t] = PREV_OUT select for track t.
  - Offset 2*TRACKS: NEXT_OUT selects, same per-track layout.
  - Offset 4*TRACKS: INNER_OUT selects, same per-track layout.
  - Offset 6*TRACKS + p*(2+SELW), per pin p: bit0 = DIR (1 = output), bit1 = REG, bits[SELW+1:2] = SRC track index into INNER_IN.
- Switch encoding for output track t of side X:
  - 0: drive 0.
  - 1: track t of the first other source.
  - 2: track t of the second other source.
  - 3: pad value of pin (t mod IO_PINS); this is 0 if that pin has DIR=1.
  - Source order: PREV_OUT from (NEXT_IN, INNER_IN); NEXT_OUT from (PREV_IN, INNER_IN); INNER_OUT from (PREV_IN, NEXT_IN).
- Switch paths are purely combinational from the active config.
- Pin p:
  - Pin register: q <= DIR ? INNER_IN[SRC] : PAD_IN[p], every cycle.
  - PAD_OE = DIR.
  - PAD_OUT = DIR ? (REG ? q : INNER_IN[SRC]) : 0.
  - Pad value seen by tracks = REG ? q : PAD_IN[p].
  - Registered mode adds exactly 1 cycle of latency.
- After DIR changes at commit, q holds stale data for one cycle. This is permitted.
- Changing the config during shift never disturbs the active routing.

Optional Feature:
Macro: CFG_PARITY_EN.
- Defined: the chain is CFG_BITS+1 long. The extra bit at the top is an even-parity bit. Commit additionally requires that the XOR of all shifted bits is 0; a parity failure sets CFG_ERR and blocks the commit. SOUT is still the chain's bit 0.
- Undefined: no parity bit, and behaviour is exactly as above.

Decomposition:
- Package io_border_pkg holds:
  - select codes SEL_OFF=0, SEL_A=1, SEL_B=2, SEL_PAD=3;
  - offset functions for side and pin fields;
  - the CFG_BITS and pin-field-width functions of TRACKS and IO_PINS.
- Sub-module border_pin_cell: one per pin, containing the pin register, DIR/REG/SRC muxing and the PAD_OUT/PAD_OE/pad-value outputs.
- The switch muxes and the scan/commit controller stay in the top level.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, CFG_DONE=0, CFG_ERR=0.
- Shift 58 bits with NEXT_OUT track 3 select=1 (bits 2*8+7:2*8+6 = 01), then drop SE; drive PREV_IN=8'h08 -> CFG_DONE pulses once and NEXT_OUT=8'h08 combinationally.
- Shift only 57 bits, then drop SE -> CFG_ERR=1, prior routing unchanged. A following correct 58-bit load clears CFG_ERR at SE rise and commits.
- Pin 0: DIR=1, REG=1, SRC=5; toggle INNER_IN[5] -> PAD_OE[0]=1, PAD_OUT[0] follows 1 cycle later. With REG=0 it follows in the same cycle.
- Pin 1: DIR=0, REG=0; INNER_OUT track 1 select=3; PAD_IN[1]=1 -> INNER_OUT[1]=1 and PAD_OE[1]=0. Set DIR=1 -> INNER_OUT[1]=0.
- Assert RST at shift bit 30, then deassert RST with SE low -> no commit, no CFG_DONE, all state 0. With CFG_PARITY_EN: a bad parity bit gives CFG_ERR=1 and no commit.
